// File: rtl/async_fifo_wr_packer_if.sv
// Narrow input stream plus FIFO write port of the write-side packer.
// The packer connects through the master modport; its environment uses slave.
interface async_fifo_wr_packer_if #(
    parameter int IN_LEN = 16,
    parameter int RATIO  = 4
);
    localparam int OUT_LEN = IN_LEN * RATIO;
    localparam int CNT_W   = $clog2(RATIO) + 1;
    localparam int FIFO_W  = OUT_LEN + CNT_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [IN_LEN-1:0] in_data;
    logic              in_last;
    logic              fifo_full;
    logic              fifo_wen;
    logic [FIFO_W-1:0] fifo_data;

    modport master (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  fifo_full,
        output in_ready,
        output fifo_wen,
        output fifo_data
    );

    modport slave (
        output in_valid,
        output in_data,
        output in_last,
        output fifo_full,
        input  in_ready,
        input  fifo_wen,
        input  fifo_data
    );
endinterface

// File: rtl/async_fifo_wr_packer_tmr.sv
// Saturating idle timer; expired stays high while the count sits at TIMEOUT.
// TIMEOUT of 0 removes the timer and expired never asserts.
module async_fifo_wr_packer_tmr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_w,
    input  logic rstn_w,
    input  logic clr,
    input  logic en,
    output logic expired
);
    if (TIMEOUT > 0) begin : g_tmr
        localparam int TMR_W = $clog2(TIMEOUT + 1);

        logic [TMR_W-1:0] tmr_q;
        logic [TMR_W-1:0] tmr_d;

        always_comb begin
            tmr_d = tmr_q;
            if (clr) begin
                tmr_d = '0;
            end else if (en && (tmr_q != TMR_W'(TIMEOUT))) begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end

        always_ff @(posedge clk_w or negedge rstn_w) begin
            if (!rstn_w) begin
                tmr_q <= '0;
            end else begin
                tmr_q <= tmr_d;
            end
        end

        assign expired = (tmr_q == TMR_W'(TIMEOUT));
    end else begin : g_no_tmr
        assign expired = 1'b0;
    end
endmodule

// File: rtl/async_fifo_wr_packer.sv
// Packs RATIO narrow beats into one FIFO word tagged {last, cnt, data}.
// Partial words flush on in_last or after TIMEOUT idle cycles.
module async_fifo_wr_packer #(
    parameter int IN_LEN  = 16,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk_w,
    input  logic                   rstn_w,
    async_fifo_wr_packer_if.master bus,
    output logic                   busy
);
    localparam int OUT_LEN = IN_LEN * RATIO;
    localparam int CNT_W   = $clog2(RATIO) + 1;
    localparam int ACC_W   = CNT_W - 1;

    logic [OUT_LEN-1:0] acc_q, acc_d;
    logic [ACC_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_LEN-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_last_q, out_last_d;

    logic               out_free;
    logic               fifo_wen;
    logic               beat_acc;
    logic               complete;
    logic               flush;
    logic               load;
    logic               acc_empty;
    logic               tmr_clr;
    logic               tmr_exp;
    logic [OUT_LEN-1:0] merged;

    // Output register frees up in the same cycle its word is written.
    assign out_free  = ~out_valid_q | ~bus.fifo_full;
    assign fifo_wen  = out_valid_q & ~bus.fifo_full;
    assign acc_empty = (acc_cnt_q == '0);
    assign beat_acc  = bus.in_valid & out_free;
    assign complete  = beat_acc & (bus.in_last | (acc_cnt_q == ACC_W'(RATIO - 1)));
    assign flush     = tmr_exp & ~acc_empty & out_free & ~beat_acc;
    assign load      = complete | flush;
    assign tmr_clr   = beat_acc | acc_empty | flush;

    always_comb begin
        merged = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            if (acc_cnt_q == ACC_W'(k)) begin
                merged[k*IN_LEN +: IN_LEN] = bus.in_data;
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_last_d  = out_last_q;
        if (fifo_wen) begin
            out_valid_d = 1'b0;
        end
        if (load) begin
            acc_d       = '0;
            acc_cnt_d   = '0;
            out_valid_d = 1'b1;
            out_data_d  = complete ? merged : acc_q;
            out_cnt_d   = {1'b0, acc_cnt_q} + CNT_W'(complete);
            out_last_d  = complete & bus.in_last;
        end else if (beat_acc) begin
            acc_d     = merged;
            acc_cnt_d = acc_cnt_q + ACC_W'(1);
        end
    end

    always_ff @(posedge clk_w or negedge rstn_w) begin
        if (!rstn_w) begin
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_last_q  <= out_last_d;
        end
    end

    async_fifo_wr_packer_tmr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmr (
        .clk_w   (clk_w),
        .rstn_w  (rstn_w),
        .clr     (tmr_clr),
        .en      (~acc_empty),
        .expired (tmr_exp)
    );

    assign bus.in_ready  = out_free;
    assign bus.fifo_wen  = fifo_wen;
    assign bus.fifo_data = {out_last_q, out_cnt_q, out_data_q};
    assign busy          = ~acc_empty | out_valid_q;
endmodule
